// File: rtl/mmu_port_arbiter.sv
// Shares the single l1mmu request port between the L1I (read-only) and L1D (read/write)
// line requesters; one owner per transaction, round-robin on ties, sticky grant timeout flag.
module mmu_port_arbiter #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int D_FIRST = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_req_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_read_data,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_done,
  output logic [LINE_W-1:0] d_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Encoding doubles as the {D,I} one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;  // 1: D owned the most recent completed grant
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             d_req;

  assign d_req = d_req_read | d_req_write;

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_req_read && d_req) state_d = last_d_q ? GNT_I : GNT_D;
        else if (d_req)          state_d = GNT_D;
        else if (i_req_read)     state_d = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (mmu_done) begin
          state_d  = IDLE;
          last_d_d = (state_q == GNT_D);
        end else if ((TIMEOUT > 0) && (cnt_q != CNT_W'(TIMEOUT))) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= (D_FIRST == 0);
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Owner's request is muxed straight through; the port reads all-zero while idle.
  always_comb begin
    mmu_req_read   = 1'b0;
    mmu_req_write  = 1'b0;
    mmu_addr       = '0;
    mmu_write_data = '0;
    case (state_q)
      GNT_I: begin
        mmu_req_read   = i_req_read;
        mmu_addr       = i_addr;
        mmu_write_data = d_write_data;
      end
      GNT_D: begin
        mmu_req_read   = d_req_read;
        mmu_req_write  = d_req_write;
        mmu_addr       = d_addr;
        mmu_write_data = d_write_data;
      end
      default: ;
    endcase
  end

  assign grant       = state_q;
  assign i_done      = mmu_done & grant[0];
  assign d_done      = mmu_done & grant[1];
  assign i_read_data = mmu_read_data;
  assign d_read_data = mmu_read_data;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Bench for mmu_port_arbiter: requester drivers push expected lines into per-port queues,
// a negedge monitor runs a rule-level arbitration model and pops the queues on every done.
module tb_mmu_port_arbiter;

  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              i_req_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_read_data;
  logic              d_req_read;
  logic              d_req_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_write_data;
  logic              d_done;
  logic [LINE_W-1:0] d_read_data;
  logic              mmu_req_read;
  logic              mmu_req_write;
  logic [ADDR_W-1:0] mmu_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;
  logic [1:0]        grant;
  logic              timeout_err;

  mmu_port_arbiter #(
    .LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .D_FIRST(1)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_req_read(i_req_read), .i_addr(i_addr), .i_done(i_done), .i_read_data(i_read_data),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_addr(d_addr),
    .d_write_data(d_write_data), .d_done(d_done), .d_read_data(d_read_data),
    .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write), .mmu_addr(mmu_addr),
    .mmu_write_data(mmu_write_data), .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mmu_mode  = 1;   // 0: withhold done, 1: fixed latency, 2: random latency
  int fixed_lat = 3;
  int stray_at  = -1;  // cycle on which the l1mmu model emits an unsolicited done

  logic [LINE_W-1:0] exp_i[$];
  logic [LINE_W-1:0] exp_d[$];
  logic [1:0]        gnt_log[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hC3A5_5A3C}};
  endfunction

  // l1mmu behaviour: reads return a pattern of the address; writes echo the line mixed with it.
  function automatic logic [LINE_W-1:0] mmu_line(input logic [ADDR_W-1:0] a, input logic wr,
                                                  input logic [LINE_W-1:0] wd);
    return wr ? (~pat(a) ^ wd) : pat(a);
  endfunction

  // l1mmu model: drives mmu_done/mmu_read_data 2 time units after each rising edge.
  initial begin : mmu_model
    int gcnt;
    int lat;
    gcnt = 0;
    lat  = 1;
    mmu_done      = 1'b0;
    mmu_read_data = '0;
    forever begin
      @(posedge sys_clk); #2;
      mmu_done      = 1'b0;
      mmu_read_data = {8{$urandom()}};
      if (cyc == stray_at) begin
        mmu_done = 1'b1;
      end else if (!rst_n || grant == 2'b00) begin
        gcnt = 0;
      end else begin
        gcnt++;
        if (gcnt == 1) lat = int'($urandom_range(1, 5));
        if (mmu_mode != 0 && gcnt >= ((mmu_mode == 2) ? lat : fixed_lat)) begin
          mmu_done      = 1'b1;
          mmu_read_data = mmu_line(mmu_addr, mmu_req_write, mmu_write_data);
        end
      end
    end
  end

  // Reference model state, advanced once per negedge from the previous negedge's samples.
  logic [1:0] m_gnt, m_last, m_exp, m_dut;
  logic       m_ireq, m_dreq, m_done, m_rst, m_err;
  int         m_cnt;

  initial begin : monitor
    logic [319:0] mux_exp;
    m_gnt = 2'b00; m_last = 2'b01; m_dut = 2'b00;
    m_ireq = 1'b0; m_dreq = 1'b0; m_done = 1'b0; m_rst = 1'b0; m_err = 1'b0;
    m_cnt = 0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n || !m_rst) begin
        m_exp = 2'b00;
        m_cnt = 0;
        if (!rst_n) begin
          m_last = 2'b01;  // D wins the first tie after reset
          m_err  = 1'b0;
        end
      end else if (m_gnt == 2'b00) begin
        m_cnt = 0;
        if (m_ireq && m_dreq) m_exp = ~m_last;
        else                  m_exp = {m_dreq, m_ireq};
      end else if (m_done) begin
        m_last = m_gnt;
        m_exp  = 2'b00;
      end else begin
        m_exp = m_gnt;
        m_cnt++;
        if (m_cnt >= TIMEOUT) m_err = 1'b1;
      end

      check("grant", grant, m_exp);
      check("timeout_err", timeout_err, m_err);
      check("done routing", {d_done, i_done}, mmu_done ? m_exp : 2'b00);

      mux_exp = '0;
      if (m_exp == 2'b01) mux_exp = {i_req_read, 1'b0, i_addr, d_write_data};
      if (m_exp == 2'b10) mux_exp = {d_req_read, d_req_write, d_addr, d_write_data};
      check("mmu port mux", {mmu_req_read, mmu_req_write, mmu_addr, mmu_write_data}, mux_exp);

      if (i_done) begin
        if (exp_i.size() == 0) check("i_done unexpected", i_done, 1'b0);
        else                   check("i_read_data", i_read_data, exp_i.pop_front());
      end
      if (d_done) begin
        if (exp_d.size() == 0) check("d_done unexpected", d_done, 1'b0);
        else                   check("d_read_data", d_read_data, exp_d.pop_front());
      end

      if (grant != 2'b00 && m_dut == 2'b00) gnt_log.push_back(grant);
      m_dut  = grant;
      m_gnt  = m_exp;
      m_done = mmu_done;
      m_ireq = i_req_read;
      m_dreq = d_req_read | d_req_write;
      m_rst  = rst_n;
    end
  end

  // Requester tasks are entered 1 time unit after a rising edge and return at the same phase.
  task automatic do_i(input logic [ADDR_W-1:0] a);
    bit seen;
    seen       = 1'b0;
    i_addr     = a;
    i_req_read = 1'b1;
    exp_i.push_back(mmu_line(a, 1'b0, '0));
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge sys_clk);
      seen = i_done;
    end
    check("i_done seen", seen, 1'b1);
    @(posedge sys_clk); #1;
    i_req_read = 1'b0;
  endtask

  task automatic do_d(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
    bit seen;
    seen         = 1'b0;
    d_addr       = a;
    d_write_data = wd;
    d_req_read   = ~wr;
    d_req_write  = wr;
    exp_d.push_back(mmu_line(a, wr, wd));
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge sys_clk);
      seen = d_done;
    end
    check("d_done seen", seen, 1'b1);
    @(posedge sys_clk); #1;
    d_req_read  = 1'b0;
    d_req_write = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int base;
    logic [1:0] g;
    rst_n = 1'b0; i_req_read = 1'b0; i_addr = '0;
    d_req_read = 1'b0; d_req_write = 1'b0; d_addr = '0; d_write_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset grant", grant, 2'b00);
    check("reset timeout_err", timeout_err, 1'b0);
    check("reset mmu_req", {mmu_req_read, mmu_req_write}, 2'b00);
    check("reset dones", {d_done, i_done}, 2'b00);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // I read alone: grant appears one edge after the request is seen.
    fork
      do_i(32'h0000_1000);
      begin
        @(negedge sys_clk); check("t1 grant before edge", grant, 2'b00);
        @(negedge sys_clk); check("t1 grant after edge", grant, 2'b01);
      end
    join
    @(posedge sys_clk); #1;

    // D write forwards address, data and the write strobe.
    fork
      do_d(1'b1, 32'h0000_2000, {32{8'hA5}});
      begin
        repeat (2) @(negedge sys_clk);
        check("t3 mmu_req", {mmu_req_read, mmu_req_write}, 2'b01);
        check("t3 mmu_addr", mmu_addr, 32'h0000_2000);
        check("t3 mmu_write_data", mmu_write_data, {32{8'hA5}});
      end
    join

    // Both requesting at the first edge after reset: D first, then I.
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    base = gnt_log.size();
    fork
      do_i(32'h0000_3040);
      do_d(1'b0, 32'h0000_5080, '0);
    join
    g = (gnt_log.size() > base) ? gnt_log[base] : 2'b00;
    check("t2 first owner", g, 2'b10);
    g = (gnt_log.size() > base + 1) ? gnt_log[base + 1] : 2'b00;
    check("t2 second owner", g, 2'b01);

    // Continuous requests from both ports alternate owners.
    base = gnt_log.size();
    fork
      for (int k = 0; k < 3; k++) do_i(32'h0001_0000 + 32'(k * 64));
      for (int k = 0; k < 3; k++) do_d(1'b0, 32'h0002_0000 + 32'(k * 64), '0);
    join
    check("t4 grant count", gnt_log.size() - base, 6);
    for (int k = 0; k < 6; k++) begin
      g = (gnt_log.size() > base + k) ? gnt_log[base + k] : 2'b00;
      check("t4 grant order", g, (k % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Randomised traffic with random l1mmu latency.
    mmu_mode = 2;
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge sys_clk); #1; end
        do_i($urandom() & 32'hFFFF_FFE0);
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge sys_clk); #1; end
        do_d(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFE0,
             {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()});
      end
    join

    // Withheld done: error rises after the 8th granted cycle, grant holds, late done completes.
    mmu_mode = 0;
    fixed_lat = 3;
    fork
      do_i(32'h0000_7000);
      begin
        repeat (9) @(negedge sys_clk);
        check("t5 err after 7 cycles", timeout_err, 1'b0);
        @(negedge sys_clk);
        check("t5 err after 8 cycles", timeout_err, 1'b1);
        repeat (3) @(negedge sys_clk);
        check("t5 err sticky", timeout_err, 1'b1);
        check("t5 grant held", grant, 2'b01);
        @(posedge sys_clk); #1;
        fixed_lat = 1;
        mmu_mode  = 1;
      end
    join
    check("t5 err after done", timeout_err, 1'b1);

    // Reset during GNT_D returns to idle at once; a late done is ignored.
    mmu_mode = 0;
    @(posedge sys_clk); #1;
    d_addr = 32'h0000_9000; d_req_read = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("t6 grant before reset", grant, 2'b10);
    rst_n = 1'b0;
    d_req_read = 1'b0;
    #1;
    check("t6 grant in reset", grant, 2'b00);
    check("t6 mmu_req in reset", {mmu_req_read, mmu_req_write}, 2'b00);
    check("t6 err cleared", timeout_err, 1'b0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    stray_at = cyc;
    @(negedge sys_clk);
    check("t6 late d_done", d_done, 1'b0);
    check("t6 late i_done", i_done, 1'b0);
    @(negedge sys_clk);
    check("t6 still idle", grant, 2'b00);

    repeat (2) @(posedge sys_clk);
    check("i queue drained", exp_i.size(), 0);
    check("d queue drained", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
